// File: rtl/sram_cmd_arbt.sv
// sram_cmd_arbt: merges the LSU and JTAG debug initiators onto one SRAM
// target port. Grants alternate round-robin, a grant presented to a stalled
// target is held until accepted, and a small in-order source-ID FIFO steers
// each target response back to the initiator that issued the command.
module sram_cmd_arbt #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int OUTS_DP = 2
) (
  input  logic              clk,
  input  logic              rst,

  // LSU initiator
  input  logic              lsu_cmd_vld,
  output logic              lsu_cmd_rdy,
  input  logic              lsu_cmd_read,
  input  logic [AW-1:0]     lsu_cmd_addr,
  input  logic [DW-1:0]     lsu_cmd_wdata,
  input  logic [DW/8-1:0]   lsu_cmd_wmask,
  output logic              lsu_rsp_vld,
  input  logic              lsu_rsp_rdy,
  output logic [DW-1:0]     lsu_rsp_rdata,
  output logic              lsu_rsp_err,

  // JTAG debug initiator
  input  logic              jtag_cmd_vld,
  output logic              jtag_cmd_rdy,
  input  logic              jtag_cmd_read,
  input  logic [AW-1:0]     jtag_cmd_addr,
  input  logic [DW-1:0]     jtag_cmd_wdata,
  input  logic [DW/8-1:0]   jtag_cmd_wmask,
  output logic              jtag_rsp_vld,
  input  logic              jtag_rsp_rdy,
  output logic [DW-1:0]     jtag_rsp_rdata,
  output logic              jtag_rsp_err,

  // SRAM target
  output logic              sram_cmd_vld,
  input  logic              sram_cmd_rdy,
  output logic              sram_cmd_read,
  output logic [AW-1:0]     sram_cmd_addr,
  output logic [DW-1:0]     sram_cmd_wdata,
  output logic [DW/8-1:0]   sram_cmd_wmask,
  input  logic              sram_rsp_vld,
  output logic              sram_rsp_rdy,
  input  logic [DW-1:0]     sram_rsp_rdata,
  input  logic              sram_rsp_err
);

  localparam int PW = (OUTS_DP > 1) ? $clog2(OUTS_DP) : 1;
  localparam int CW = $clog2(OUTS_DP + 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(OUTS_DP - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(OUTS_DP);

  // Source IDs
  localparam logic SRC_LSU  = 1'b0;
  localparam logic SRC_JTAG = 1'b1;

  // Arbitration state
  logic rr_last_q, rr_last_d;
  logic lock_q, lock_d;
  logic lock_id_q, lock_id_d;

  // Outstanding source-ID FIFO
  logic [OUTS_DP-1:0] fifo_q, fifo_d;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic fifo_nfull;
  logic fifo_nempty;
  logic head;

  logic grant;
  logic grant_vld;
  logic any_vld;
  logic cmd_vld;
  logic cmd_rdy_ok;
  logic cmd_acc;
  logic cmd_stall;
  logic rsp_rdy_int;
  logic rsp_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  assign fifo_nfull  = (cnt_q != CNT_FULL);
  assign fifo_nempty = (cnt_q != '0);
  assign head        = fifo_q[rd_ptr_q];

  // Grant selection: a held lock wins, then a lone requester, then the
  // source that did not win last time. With nobody requesting the grant
  // rests on the next round-robin source.
  always_comb begin
    grant = ~rr_last_q;
    if (lock_q) begin
      grant = lock_id_q;
    end else if (lsu_cmd_vld && !jtag_cmd_vld) begin
      grant = SRC_LSU;
    end else if (jtag_cmd_vld && !lsu_cmd_vld) begin
      grant = SRC_JTAG;
    end
  end

  assign any_vld     = lsu_cmd_vld | jtag_cmd_vld;
  assign grant_vld   = (grant == SRC_JTAG) ? jtag_cmd_vld : lsu_cmd_vld;
  assign cmd_vld     = grant_vld & fifo_nfull;
  assign cmd_rdy_ok  = sram_cmd_rdy & fifo_nfull;
  assign cmd_acc     = cmd_vld & sram_cmd_rdy;
  assign cmd_stall   = cmd_vld & ~sram_cmd_rdy;
  assign rsp_rdy_int = fifo_nempty & ((head == SRC_JTAG) ? jtag_rsp_rdy : lsu_rsp_rdy);
  assign rsp_pop     = sram_rsp_vld & rsp_rdy_int;

  // Command-side outputs: forward the granted initiator's fields; all
  // handshake and data outputs are held low while reset is asserted.
  always_comb begin
    sram_cmd_vld   = 1'b0;
    sram_cmd_read  = 1'b0;
    sram_cmd_addr  = '0;
    sram_cmd_wdata = '0;
    sram_cmd_wmask = '0;
    lsu_cmd_rdy    = 1'b0;
    jtag_cmd_rdy   = 1'b0;
    if (rst) begin
      sram_cmd_vld = cmd_vld;
      lsu_cmd_rdy  = (grant == SRC_LSU)  & cmd_rdy_ok;
      jtag_cmd_rdy = (grant == SRC_JTAG) & cmd_rdy_ok;
      if (any_vld) begin
        if (grant == SRC_JTAG) begin
          sram_cmd_read  = jtag_cmd_read;
          sram_cmd_addr  = jtag_cmd_addr;
          sram_cmd_wdata = jtag_cmd_wdata;
          sram_cmd_wmask = jtag_cmd_wmask;
        end else begin
          sram_cmd_read  = lsu_cmd_read;
          sram_cmd_addr  = lsu_cmd_addr;
          sram_cmd_wdata = lsu_cmd_wdata;
          sram_cmd_wmask = lsu_cmd_wmask;
        end
      end
    end
  end

  // Response-side outputs: steer the target response to the FIFO head
  // source; the other initiator sees zeros.
  always_comb begin
    lsu_rsp_vld    = 1'b0;
    lsu_rsp_rdata  = '0;
    lsu_rsp_err    = 1'b0;
    jtag_rsp_vld   = 1'b0;
    jtag_rsp_rdata = '0;
    jtag_rsp_err   = 1'b0;
    sram_rsp_rdy   = 1'b0;
    if (rst && fifo_nempty) begin
      sram_rsp_rdy = rsp_rdy_int;
      if (head == SRC_JTAG) begin
        jtag_rsp_vld   = sram_rsp_vld;
        jtag_rsp_rdata = sram_rsp_rdata;
        jtag_rsp_err   = sram_rsp_err;
      end else begin
        lsu_rsp_vld    = sram_rsp_vld;
        lsu_rsp_rdata  = sram_rsp_rdata;
        lsu_rsp_err    = sram_rsp_err;
      end
    end
  end

  // Next-state: lock on a stalled presentation, record the winner and push
  // its ID on acceptance, advance the read side on each delivered response.
  always_comb begin
    rr_last_d = rr_last_q;
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    fifo_d    = fifo_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;

    if (cmd_acc) begin
      fifo_d[wr_ptr_q] = grant;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
      rr_last_d        = grant;
      lock_d           = 1'b0;
    end else if (cmd_stall) begin
      lock_d    = 1'b1;
      lock_id_d = grant;
    end

    if (rsp_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end

    case ({cmd_acc, rsp_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Control state; reset empties the FIFO and biases the first tie to LSU.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_last_q <= SRC_JTAG;
      lock_q    <= 1'b0;
      lock_id_q <= SRC_LSU;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
    end else begin
      rr_last_q <= rr_last_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  // FIFO storage; contents are only meaningful below the count, so no reset.
  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end

  // The target may only respond while at least one command is outstanding.
  a_no_unsolicited_rsp: assert property (
    @(posedge clk) disable iff (!rst) !(sram_rsp_vld && !fifo_nempty));

endmodule

// File: tb/tb_sram_cmd_arbt.sv
// tb_sram_cmd_arbt: directed scenarios plus randomized traffic for
// sram_cmd_arbt, every cycle compared against a queue-based reference model.
module tb_sram_cmd_arbt;
  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int MW      = DW / 8;
  localparam int OUTS_DP = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          lsu_cmd_vld, lsu_cmd_rdy, lsu_cmd_read;
  logic [AW-1:0] lsu_cmd_addr;
  logic [DW-1:0] lsu_cmd_wdata;
  logic [MW-1:0] lsu_cmd_wmask;
  logic          lsu_rsp_vld, lsu_rsp_rdy, lsu_rsp_err;
  logic [DW-1:0] lsu_rsp_rdata;
  logic          jtag_cmd_vld, jtag_cmd_rdy, jtag_cmd_read;
  logic [AW-1:0] jtag_cmd_addr;
  logic [DW-1:0] jtag_cmd_wdata;
  logic [MW-1:0] jtag_cmd_wmask;
  logic          jtag_rsp_vld, jtag_rsp_rdy, jtag_rsp_err;
  logic [DW-1:0] jtag_rsp_rdata;
  logic          sram_cmd_vld, sram_cmd_rdy, sram_cmd_read;
  logic [AW-1:0] sram_cmd_addr;
  logic [DW-1:0] sram_cmd_wdata;
  logic [MW-1:0] sram_cmd_wmask;
  logic          sram_rsp_vld, sram_rsp_rdy, sram_rsp_err;
  logic [DW-1:0] sram_rsp_rdata;

  always #5 clk = ~clk;

  sram_cmd_arbt #(.AW(AW), .DW(DW), .OUTS_DP(OUTS_DP)) dut (
    .clk(clk), .rst(rst),
    .lsu_cmd_vld(lsu_cmd_vld), .lsu_cmd_rdy(lsu_cmd_rdy), .lsu_cmd_read(lsu_cmd_read),
    .lsu_cmd_addr(lsu_cmd_addr), .lsu_cmd_wdata(lsu_cmd_wdata), .lsu_cmd_wmask(lsu_cmd_wmask),
    .lsu_rsp_vld(lsu_rsp_vld), .lsu_rsp_rdy(lsu_rsp_rdy), .lsu_rsp_rdata(lsu_rsp_rdata),
    .lsu_rsp_err(lsu_rsp_err),
    .jtag_cmd_vld(jtag_cmd_vld), .jtag_cmd_rdy(jtag_cmd_rdy), .jtag_cmd_read(jtag_cmd_read),
    .jtag_cmd_addr(jtag_cmd_addr), .jtag_cmd_wdata(jtag_cmd_wdata), .jtag_cmd_wmask(jtag_cmd_wmask),
    .jtag_rsp_vld(jtag_rsp_vld), .jtag_rsp_rdy(jtag_rsp_rdy), .jtag_rsp_rdata(jtag_rsp_rdata),
    .jtag_rsp_err(jtag_rsp_err),
    .sram_cmd_vld(sram_cmd_vld), .sram_cmd_rdy(sram_cmd_rdy), .sram_cmd_read(sram_cmd_read),
    .sram_cmd_addr(sram_cmd_addr), .sram_cmd_wdata(sram_cmd_wdata), .sram_cmd_wmask(sram_cmd_wmask),
    .sram_rsp_vld(sram_rsp_vld), .sram_rsp_rdy(sram_rsp_rdy), .sram_rsp_rdata(sram_rsp_rdata),
    .sram_rsp_err(sram_rsp_err)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: outstanding source IDs in issue order, plus the
  // round-robin memory and the held grant.
  bit m_outs[$];
  bit m_rr_last, m_lock, m_lock_id;
  bit m_g, m_acc, m_pop, m_stall;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_outs.delete();
    m_rr_last = 1'b1;
    m_lock    = 1'b0;
    m_lock_id = 1'b0;
    m_g       = 1'b0;
    m_acc     = 1'b0;
    m_pop     = 1'b0;
    m_stall   = 1'b0;
  endfunction

  task automatic check_reset_outputs(input string pfx);
    check_eq({pfx, "_ctl"}, 64'({sram_cmd_vld, lsu_cmd_rdy, jtag_cmd_rdy,
                                 lsu_rsp_vld, jtag_rsp_vld, sram_rsp_rdy}), 64'(0));
    check_eq({pfx, "_cmd"}, 64'({sram_cmd_addr, sram_cmd_wdata}), 64'(0));
    check_eq({pfx, "_misc"}, 64'({sram_cmd_wmask, sram_cmd_read, lsu_rsp_err, jtag_rsp_err}), 64'(0));
    check_eq({pfx, "_rdata"}, 64'({lsu_rsp_rdata, jtag_rsp_rdata}), 64'(0));
  endtask

  // Compare every output against the model at the falling edge and note
  // which handshakes the model expects to complete at the next rising edge.
  task automatic sample();
    bit room, gv, any, nempty, head, e_rdy;
    @(negedge clk);
    if (!rst) begin
      check_reset_outputs("rst");
      m_acc = 1'b0; m_pop = 1'b0; m_stall = 1'b0;
      return;
    end
    if (m_lock)                           m_g = m_lock_id;
    else if (lsu_cmd_vld && !jtag_cmd_vld) m_g = 1'b0;
    else if (jtag_cmd_vld && !lsu_cmd_vld) m_g = 1'b1;
    else                                   m_g = !m_rr_last;
    gv   = m_g ? jtag_cmd_vld : lsu_cmd_vld;
    any  = lsu_cmd_vld || jtag_cmd_vld;
    room = (m_outs.size() < OUTS_DP);
    check_eq("sram_cmd_vld", 64'(sram_cmd_vld), 64'(gv && room));
    check_eq("lsu_cmd_rdy",  64'(lsu_cmd_rdy),  64'(!m_g && sram_cmd_rdy && room));
    check_eq("jtag_cmd_rdy", 64'(jtag_cmd_rdy), 64'(m_g && sram_cmd_rdy && room));
    check_eq("sram_cmd_addr", 64'(sram_cmd_addr),
             !any ? 64'(0) : (m_g ? 64'(jtag_cmd_addr) : 64'(lsu_cmd_addr)));
    check_eq("sram_cmd_wdata", 64'(sram_cmd_wdata),
             !any ? 64'(0) : (m_g ? 64'(jtag_cmd_wdata) : 64'(lsu_cmd_wdata)));
    check_eq("sram_cmd_wmask_read", 64'({sram_cmd_wmask, sram_cmd_read}),
             !any ? 64'(0) : (m_g ? 64'({jtag_cmd_wmask, jtag_cmd_read})
                                  : 64'({lsu_cmd_wmask, lsu_cmd_read})));
    nempty = (m_outs.size() != 0);
    head   = nempty ? m_outs[0] : 1'b0;
    e_rdy  = nempty && (head ? jtag_rsp_rdy : lsu_rsp_rdy);
    check_eq("sram_rsp_rdy", 64'(sram_rsp_rdy), 64'(e_rdy));
    check_eq("lsu_rsp_vld",  64'(lsu_rsp_vld),  64'(nempty && !head && sram_rsp_vld));
    check_eq("jtag_rsp_vld", 64'(jtag_rsp_vld), 64'(nempty && head && sram_rsp_vld));
    check_eq("lsu_rsp_data", 64'({lsu_rsp_err, lsu_rsp_rdata}),
             (nempty && !head) ? 64'({sram_rsp_err, sram_rsp_rdata}) : 64'(0));
    check_eq("jtag_rsp_data", 64'({jtag_rsp_err, jtag_rsp_rdata}),
             (nempty && head) ? 64'({sram_rsp_err, sram_rsp_rdata}) : 64'(0));
    m_acc   = gv && room && sram_cmd_rdy;
    m_stall = gv && room && !sram_cmd_rdy;
    m_pop   = nempty && sram_rsp_vld && e_rdy;
  endtask

  task automatic advance();
    @(posedge clk);
    if (rst) begin
      if (m_pop) void'(m_outs.pop_front());
      if (m_acc) begin
        m_outs.push_back(m_g);
        m_rr_last = m_g;
        m_lock    = 1'b0;
      end else if (m_stall) begin
        m_lock    = 1'b1;
        m_lock_id = m_g;
      end
    end
    #1;
  endtask

  task automatic cycle();
    sample();
    advance();
  endtask

  task automatic drain();
    lsu_cmd_vld  = 1'b0;
    jtag_cmd_vld = 1'b0;
    lsu_rsp_rdy  = 1'b1;
    jtag_rsp_rdy = 1'b1;
    for (int i = 0; i < 2 * OUTS_DP + 2; i++) begin
      if (m_outs.size() == 0) break;
      sram_rsp_vld   = 1'b1;
      sram_rsp_rdata = $urandom;
      cycle();
    end
    sram_rsp_vld = 1'b0;
  endtask

  task automatic lsu_cmd(input logic [AW-1:0] a, input logic rd);
    lsu_cmd_vld = 1'b1; lsu_cmd_addr = a; lsu_cmd_read = rd;
    lsu_cmd_wdata = $urandom; lsu_cmd_wmask = MW'($urandom);
  endtask

  task automatic jtag_cmd(input logic [AW-1:0] a, input logic rd);
    jtag_cmd_vld = 1'b1; jtag_cmd_addr = a; jtag_cmd_read = rd;
    jtag_cmd_wdata = $urandom; jtag_cmd_wmask = MW'($urandom);
  endtask

  // Random initiators hold an unaccepted command; random target responds
  // only while something is outstanding.
  task automatic rand_drive();
    bit l_hold, j_hold;
    l_hold = lsu_cmd_vld && !(m_acc && !m_g);
    j_hold = jtag_cmd_vld && !(m_acc && m_g);
    if (!l_hold) begin
      lsu_cmd($urandom, 1'($urandom));
      lsu_cmd_vld = ($urandom_range(0, 2) != 0);
    end
    if (!j_hold) begin
      jtag_cmd($urandom, 1'($urandom));
      jtag_cmd_vld = ($urandom_range(0, 2) != 0);
    end
    sram_cmd_rdy   = ($urandom_range(0, 3) != 0);
    sram_rsp_vld   = (m_outs.size() != 0) && ($urandom_range(0, 1) != 0);
    sram_rsp_rdata = $urandom;
    sram_rsp_err   = ($urandom_range(0, 7) == 0);
    lsu_rsp_rdy    = ($urandom_range(0, 3) != 0);
    jtag_rsp_rdy   = ($urandom_range(0, 3) != 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish (t=%0t)", $time);
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    model_reset();
    lsu_cmd(32'h0, 1'b0); jtag_cmd(32'h0, 1'b0);
    lsu_cmd_vld = 1'b1; jtag_cmd_vld = 1'b0;
    sram_cmd_rdy = 1'b1; sram_rsp_vld = 1'b0; sram_rsp_rdata = '0; sram_rsp_err = 1'b0;
    lsu_rsp_rdy = 1'b1; jtag_rsp_rdy = 1'b1;
    repeat (2) cycle();
    rst = 1'b1;
    lsu_cmd_vld = 1'b0;
    cycle();

    // Both initiators requesting every cycle: grants alternate, LSU first.
    lsu_cmd(32'hA000_0000, 1'b1);
    jtag_cmd(32'hB000_0000, 1'b0);
    sram_cmd_rdy = 1'b1;
    for (int k = 0; k < 6; k++) begin
      sram_rsp_vld   = (m_outs.size() != 0);
      sram_rsp_rdata = $urandom;
      sample();
      check_eq("alt_grant", 64'(sram_cmd_addr),
               (k % 2 == 0) ? 64'(32'hA000_0000) : 64'(32'hB000_0000));
      advance();
    end
    drain();

    // Lone LSU read and its routed response.
    lsu_cmd(32'h8000_0010, 1'b1);
    sample();
    check_eq("t1_addr", 64'(sram_cmd_addr), 64'(32'h8000_0010));
    check_eq("t1_vld_read", 64'({sram_cmd_vld, sram_cmd_read}), 64'(2'b11));
    advance();
    lsu_cmd_vld = 1'b0;
    sram_rsp_vld = 1'b1; sram_rsp_rdata = 32'hDEAD_BEEF; sram_rsp_err = 1'b0;
    sample();
    check_eq("t1_lsu_rsp", 64'({lsu_rsp_vld, lsu_rsp_rdata}), 64'({1'b1, 32'hDEAD_BEEF}));
    check_eq("t1_jtag_rsp", 64'({jtag_rsp_vld, jtag_rsp_rdata}), 64'(0));
    advance();
    sram_rsp_vld = 1'b0;

    // Make JTAG the last winner so an unlocked tie would favour LSU.
    jtag_cmd(32'hB000_0100, 1'b0);
    cycle();
    drain();

    // Lock: JTAG stalled for 3 cycles, LSU joins in cycle 2.
    jtag_cmd(32'hB000_0200, 1'b1);
    sram_cmd_rdy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) lsu_cmd(32'hA000_0200, 1'b1);
      sample();
      check_eq("lock_addr", 64'(sram_cmd_addr), 64'(32'hB000_0200));
      check_eq("lock_lsu_rdy", 64'(lsu_cmd_rdy), 64'(0));
      advance();
    end
    sram_cmd_rdy = 1'b1;
    sample();
    check_eq("lock_accept", 64'({sram_cmd_addr, jtag_cmd_rdy, lsu_cmd_rdy}),
             64'({32'hB000_0200, 2'b10}));
    advance();
    jtag_cmd_vld = 1'b0;
    sample();
    check_eq("lock_next_lsu", 64'({sram_cmd_addr, lsu_cmd_rdy}), 64'({32'hA000_0200, 1'b1}));
    advance();
    lsu_cmd_vld = 1'b0;
    drain();

    // Full FIFO: third command blocked; pop does not pass through.
    lsu_cmd(32'hA000_0300, 1'b1);
    sram_cmd_rdy = 1'b1;
    repeat (2) cycle();
    sample();
    check_eq("full_blk", 64'({lsu_cmd_rdy, sram_cmd_vld}), 64'(0));
    advance();
    sram_rsp_vld = 1'b1; lsu_rsp_rdy = 1'b1;
    sample();
    check_eq("full_pop_rdy", 64'({lsu_cmd_rdy, sram_rsp_rdy}), 64'(2'b01));
    advance();
    sram_rsp_vld = 1'b0;
    sample();
    check_eq("full_after_pop", 64'({lsu_cmd_rdy, sram_cmd_vld}), 64'(2'b11));
    advance();
    lsu_cmd_vld = 1'b0;
    drain();

    // In-order routing with the LSU response stalled.
    lsu_cmd(32'hA000_0400, 1'b1);
    cycle();
    lsu_cmd_vld = 1'b0;
    jtag_cmd(32'hB000_0400, 1'b1);
    cycle();
    jtag_cmd_vld = 1'b0;
    sram_rsp_vld = 1'b1; sram_rsp_rdata = 32'h1111;
    lsu_rsp_rdy = 1'b0; jtag_rsp_rdy = 1'b1;
    repeat (2) begin
      sample();
      check_eq("ord_stall", 64'({sram_rsp_rdy, lsu_rsp_vld, jtag_rsp_vld}), 64'(3'b010));
      check_eq("ord_lsu_data", 64'(lsu_rsp_rdata), 64'(32'h1111));
      advance();
    end
    lsu_rsp_rdy = 1'b1;
    sample();
    check_eq("ord_lsu_pop", 64'({sram_rsp_rdy, lsu_rsp_vld}), 64'(2'b11));
    advance();
    sram_rsp_rdata = 32'h2222;
    sample();
    check_eq("ord_jtag", 64'({jtag_rsp_vld, lsu_rsp_vld, jtag_rsp_rdata}),
             64'({2'b10, 32'h2222}));
    advance();
    sram_rsp_vld = 1'b0;

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      rand_drive();
      cycle();
    end
    drain();

    // Asynchronous reset with two commands outstanding.
    sram_cmd_rdy = 1'b1;
    lsu_cmd(32'hA000_0500, 1'b0);
    repeat (2) cycle();
    jtag_cmd(32'hB000_0500, 1'b0);
    sram_rsp_vld = 1'b1; lsu_rsp_rdy = 1'b1; jtag_rsp_rdy = 1'b1;
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("arst");
    cycle();
    rst = 1'b1;
    lsu_cmd_vld = 1'b0; jtag_cmd_vld = 1'b0;
    sram_rsp_vld = 1'b1;
    #1;
    check_eq("unsolicited_rsp", 64'({sram_rsp_rdy, lsu_rsp_vld, jtag_rsp_vld}), 64'(0));
    sram_rsp_vld = 1'b0;
    lsu_cmd(32'hA000_0600, 1'b1);
    jtag_cmd(32'hB000_0600, 1'b1);
    sample();
    check_eq("post_rst_tie", 64'({sram_cmd_addr, lsu_cmd_rdy}), 64'({32'hA000_0600, 1'b1}));
    advance();
    lsu_cmd_vld = 1'b0; jtag_cmd_vld = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sram_cmd_arbt.md
# sram_cmd_arbt

Two-initiator to one-target arbiter for the core's valid/ready cmd/rsp memory interface. It merges the LSU port and the JTAG debug port onto a single SRAM target port. Initiators are served round-robin, a held grant is locked until accepted, and each response is routed back by a small in-order outstanding FIFO. It is the merge-side counterpart to the address-based splitters and sits directly in front of the SRAM controller.

## Interface
- AW, 32, address width
- DW, 32, data width; byte-mask width is DW/8
- OUTS_DP, 2, maximum outstanding commands (source-ID FIFO depth, ≥1)

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset
- lsu_cmd_vld / jtag_cmd_vld  in  1  initiator command valid
- lsu_cmd_rdy / jtag_cmd_rdy  out  1  initiator command ready
- lsu_cmd_read / jtag_cmd_read  in  1  1=read, 0=write
- lsu_cmd_addr / jtag_cmd_addr  in  AW  address
- lsu_cmd_wdata / jtag_cmd_wdata  in  DW  write data
- lsu_cmd_wmask / jtag_cmd_wmask  in  DW/8  byte enables
- lsu_rsp_vld / jtag_rsp_vld  out  1  response valid
- lsu_rsp_rdy / jtag_rsp_rdy  in  1  response ready
- lsu_rsp_rdata / jtag_rsp_rdata  out  DW  read data
- lsu_rsp_err / jtag_rsp_err  out  1  error
- sram_cmd_vld  out  1; sram_cmd_rdy  in  1
- sram_cmd_read  out  1; sram_cmd_addr  out  AW; sram_cmd_wdata  out  DW; sram_cmd_wmask  out  DW/8
- sram_rsp_vld  in  1; sram_rsp_rdy  out  1; sram_rsp_rdata  in  DW; sram_rsp_err  in  1

## Operation
- State:
  - rr_last (1 bit, ID of last accepted source; LSU=0, JTAG=1)
  - lock (1 bit) with lock_id
  - source-ID FIFO, OUTS_DP×1 bit, read/write pointers plus count
- Grant, in priority order:
  - lock=1 → lock_id.
  - Exactly one valid → that source.
  - Both valid → the source ≠ rr_last.
- Lock: set, with lock_id=grant, when sram_cmd_vld=1 and sram_cmd_rdy=0. Cleared on acceptance. A presented command is never switched away from before it is accepted.
- Acceptance: sram_cmd_vld & sram_cmd_rdy.
  - Pushes grant ID into the FIFO.
  - Sets rr_last=grant.
- sram_cmd_vld = granted initiator's cmd_vld & fifo_not_full.
- sram_cmd_read/addr/wdata/wmask = granted initiator's fields. All zero when no initiator is valid.
- <src>_cmd_rdy = (grant==src) & sram_cmd_rdy & fifo_not_full. The non-granted source sees 0.
- Response routing:
  - head = FIFO head ID.
  - <head>_rsp_vld = sram_rsp_vld & fifo_not_empty. The other source's rsp_vld = 0.
  - rdata and err are driven to the head source. The non-head source sees zeros.
  - sram_rsp_rdy = fifo_not_empty & <head>_rsp_rdy.
- Pop: sram_rsp_vld & sram_rsp_rdy.
- Push and pop in the same cycle are legal; count is unchanged.
- A push while full is impossible: vld/rdy are gated by fifo_not_full. A pop while full does not enable a same-cycle push; there is no pass-through.
- Responses from the target are in order. sram_rsp_vld while the FIFO is empty is ignored (rdy=0) and is a protocol violation flagged by assertion.

## Timing
- Command path is zero-latency combinational, initiator ↔ target. Response path is zero-latency combinational.
- FIFO, lock and rr_last update on the clk rising edge following the handshake.
- Reset (rst=0, async):
  - FIFO empty, lock=0, rr_last=1, so LSU wins the first tie.
  - While rst=0, all *_vld and *_rdy outputs are forced to 0 and data outputs to 0.
- Reset mid-transaction discards outstanding IDs. Initiators are reset by the same rst.
- Throughput: one command per cycle while not full, up to OUTS_DP in flight. With the FIFO full, cmd_rdy returns the cycle after a pop.

## Test plan
- LSU read of 0x8000_0010 alone, sram_cmd_rdy=1 → sram_cmd_addr=0x8000_0010 in the same cycle. Target response rdata=0xDEADBEEF appears only on lsu_rsp_rdata/vld; jtag_rsp_vld=0.
- Both valid every cycle, sram_cmd_rdy=1, responses returned promptly → grants alternate LSU, JTAG, LSU, JTAG. The first grant after reset is LSU.
- Lock: JTAG valid, sram_cmd_rdy=0 for 3 cycles, LSU asserts valid in cycle 2 → sram_cmd_addr stays at the JTAG address until accepted. LSU is granted the cycle after.
- Full FIFO (OUTS_DP=2): two accepted LSU commands with no response → a third command sees lsu_cmd_rdy=0 and sram_cmd_vld=0. A pop plus a new command in the same cycle → rdy=0 that cycle and 1 the next.
- Ordering: LSU cmd then JTAG cmd. Responses 0x1111 then 0x2222, with jtag_rsp_rdy=1 and lsu_rsp_rdy=0 for 2 cycles → target stalled (sram_rsp_rdy=0). 0x1111 goes to LSU, then 0x2222 to JTAG.
- Async reset asserted with 2 outstanding → all vld/rdy drop immediately. After release the FIFO is empty and an unsolicited sram_rsp_vld gets sram_rsp_rdy=0.
